spi_dma_seq: RTL and testbench
==============================

Name: spi_dma_seq

Overview:
- Transfer sequencer for the SPI DMA engine.
- Takes a transfer command (base address, word count, SCLK divider) from the AXI4-Lite register file.
- Fetches 32-bit words from memory over a simple request/ack read port and shifts them out as an SPI master: mode 0, MSB first, chip-select held across the whole transfer.
- Captures MISO into a receive word and reports busy, done and abort status back to the register file.

Parameters:
- ADDR_W, 32, memory address width.
- LEN_W, 16, word-count width.
- DIV_W, 8, SCLK divider width.

Ports:
- ACLK  in  1  system clock
- ARESET  in  1  asynchronous, active-high reset
- cfg_start  in  1  one-cycle start pulse from register file
- cfg_abort  in  1  one-cycle abort pulse
- cfg_addr  in  ADDR_W  base byte address (word aligned; bits[1:0] ignored)
- cfg_len  in  LEN_W  number of 32-bit words
- cfg_div  in  DIV_W  ACLK cycles per SCLK half-period; 0 is treated as 1
- rd_req  out  1  memory read request
- rd_addr  out  ADDR_W  read address
- rd_ack  in  1  read acknowledge; rd_data is valid in the same cycle
- rd_data  in  32  read data
- spi_sclk  out  1  SPI clock
- spi_mosi  out  1  SPI data out
- spi_miso  in  1  SPI data in
- spi_cs_n  out  1  chip select, active low
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse on normal completion
- aborted  out  1  sticky flag; cleared by the next accepted cfg_start
- rx_word  out  32  last fully received MISO word
- words_left  out  LEN_W  remaining word count

Behaviour:
- Reset values (while ARESET=1, asynchronously): state IDLE, rd_req=0, rd_addr=0, spi_sclk=0, spi_mosi=0, spi_cs_n=1, busy=0, done=0, aborted=0, rx_word=0, words_left=0.
- Latching:
  - cfg_addr, cfg_len and cfg_div are latched on an accepted cfg_start.
  - Later changes to the config inputs have no effect on the transfer in flight.
- States: IDLE, FETCH, CS_SETUP, SHIFT, NEXT, CS_HOLD.
- IDLE:
  - cfg_start=1 and cfg_len!=0 -> FETCH next cycle, with busy=1, rd_req=1, rd_addr=cfg_addr&~3, aborted cleared.
  - cfg_start=1 and cfg_len=0 -> done=1 the next cycle; cs_n never asserts and busy never rises.
  - cfg_start while busy is ignored.
- FETCH:
  - rd_req is held high and rd_addr stable until rd_ack is seen.
  - On rd_ack: capture rd_data into the shift register; drop rd_req next cycle; decrement words_left.
  - First word -> CS_SETUP. Later words -> SHIFT directly.
- CS_SETUP:
  - spi_cs_n=0 and spi_mosi=bit31 of the word.
  - Wait div cycles, then go to SHIFT.
- SHIFT:
  - sclk low phase lasts div cycles; sclk then rises and MISO is sampled on the rising edge.
  - sclk high phase lasts div cycles; sclk then falls and mosi advances to the next bit.
  - 32 bits take 64*div cycles. After the 32nd falling edge: rx_word is updated, then go to NEXT.
- NEXT:
  - words_left!=0 -> FETCH with rd_addr+=4 (wraps modulo 2^ADDR_W).
  - words_left=0 -> CS_HOLD.
  - sclk stays low and cs_n stays low during the inter-word gap.
- CS_HOLD:
  - Wait div cycles, then cs_n=1 and done=1 for one cycle; busy=0 and state returns to IDLE in that same cycle.
- Abort: cfg_abort in any non-IDLE state -> next cycle state=IDLE, rd_req=0, cs_n=1, sclk=0, mosi=0, busy=0, aborted=1, done not pulsed.
  - A pending rd_ack after abort is ignored.
  - cfg_abort in IDLE has no effect.
- Simultaneous cfg_start and cfg_abort in IDLE: start wins.
- ARESET mid-transfer: outputs go immediately to their reset values; the transfer is lost.
- A divider of 0 behaves exactly as 1.

Test Plan:
- Start addr=0x1000, len=1, div=2, rd_data=0xA5A5_0F0F with ack one cycle after req, MISO looped to MOSI -> exactly 32 SCLK pulses of 4 ACLK period each, MOSI pattern 0xA5A50F0F MSB first, rx_word=0xA5A50F0F, one done pulse, cs_n high afterwards.
- len=3, addr=0x2000, ack latency 5 cycles -> rd_addr sequence 0x2000, 0x2004, 0x2008; cs_n low continuously; sclk low during gaps; words_left steps 2, 1, 0; exactly 96 rising edges.
- len=0 start -> done pulse one cycle after start; no rd_req, no cs_n assertion, busy stays 0.
- Abort during word 2 of len=4 -> next cycle cs_n=1, rd_req=0, busy=0, aborted=1, no done. A following start with len=1 clears aborted and completes normally.
- div=0 vs div=1 with identical stimulus -> cycle-identical waveforms. cfg_start pulsed while busy -> ignored, latched config unchanged. addr=0xFFFF_FFFC with len=2 -> second rd_addr=0x0000_0000.
- Assert ARESET mid-SHIFT -> all outputs take reset values asynchronously; after release, a new start runs normally.

Source files
------------

// File: rtl/spi_dma_seq.sv
// spi_dma_seq: transfer sequencer for the SPI DMA engine.
// Latches a command (base address, word count, SCLK divider), fetches 32-bit
// words over a req/ack read port and shifts them out as a mode-0, MSB-first
// SPI master with chip-select held across the whole transfer. MISO is
// captured on each rising SCLK into rx_word.
// Ports:
//   ACLK, ARESET                  clock, async active-high reset
//   cfg_start/abort/addr/len/div  command from the register file
//   rd_req/rd_addr/rd_ack/rd_data memory read port (data valid with ack)
//   spi_sclk/mosi/miso/cs_n       SPI master pins
//   busy/done/aborted/rx_word/words_left  status back to the register file
module spi_dma_seq #(
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16,
  parameter int DIV_W  = 8
) (
  input  logic              ACLK,
  input  logic              ARESET,
  input  logic              cfg_start,
  input  logic              cfg_abort,
  input  logic [ADDR_W-1:0] cfg_addr,
  input  logic [LEN_W-1:0]  cfg_len,
  input  logic [DIV_W-1:0]  cfg_div,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [31:0]       rd_data,
  output logic              spi_sclk,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              spi_cs_n,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [31:0]       rx_word,
  output logic [LEN_W-1:0]  words_left
);

  typedef enum logic [2:0] {IDLE, FETCH, CS_SETUP, SHIFT, NEXT, CS_HOLD} state_t;

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  left_q;
  logic [DIV_W-1:0]  div_q, cnt_q;
  logic [4:0]        bit_q;
  logic [31:0]       tx_sh, rx_sh, rx_q;
  logic              sclk_q, first_q, done_q, abort_q;
  logic              tick, timed, abort_hit;
  logic              unused_addr_lsb;

  // word alignment: the low address bits are dropped on latch
  assign unused_addr_lsb = ^cfg_addr[1:0];

  // div_q is never 0 (0 is folded to 1 on latch), so div_q-1 is safe
  assign tick      = (cnt_q == div_q - DIV_W'(1));
  assign timed     = (state == CS_SETUP) || (state == SHIFT) || (state == CS_HOLD);
  assign abort_hit = cfg_abort && (state != IDLE);

  // state register
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) state <= IDLE;
    else        state <= state_nxt;
  end

  // next-state logic
  always_comb begin
    state_nxt = state;
    if (abort_hit) state_nxt = IDLE;
    else begin
      unique case (state)
        IDLE:     if (cfg_start && cfg_len != '0) state_nxt = FETCH;
        FETCH:    if (rd_ack) state_nxt = first_q ? CS_SETUP : SHIFT;
        CS_SETUP: if (tick) state_nxt = SHIFT;
        // last falling edge of the word
        SHIFT:    if (tick && sclk_q && bit_q == 5'd31) state_nxt = NEXT;
        NEXT:     state_nxt = (left_q != '0) ? FETCH : CS_HOLD;
        CS_HOLD:  if (tick) state_nxt = IDLE;
        default:  state_nxt = IDLE;
      endcase
    end
  end

  // outputs decoded from state
  always_comb begin
    rd_req   = (state == FETCH);
    busy     = (state != IDLE);
    // CS stays low through inter-word fetches, high only before the first word
    spi_cs_n = !((state == CS_SETUP) || (state == SHIFT) || (state == NEXT) ||
                 (state == CS_HOLD)  || (state == FETCH && !first_q));
    spi_mosi = ((state == CS_SETUP) || (state == SHIFT)) ? tx_sh[31] : 1'b0;
  end

  assign rd_addr    = addr_q;
  assign spi_sclk   = sclk_q;
  assign done       = done_q;
  assign aborted    = abort_q;
  assign rx_word    = rx_q;
  assign words_left = left_q;

  // datapath
  always_ff @(posedge ACLK or posedge ARESET) begin
    if (ARESET) begin
      addr_q  <= '0;
      left_q  <= '0;
      div_q   <= DIV_W'(1);
      cnt_q   <= '0;
      bit_q   <= '0;
      tx_sh   <= '0;
      rx_sh   <= '0;
      rx_q    <= '0;
      sclk_q  <= 1'b0;
      first_q <= 1'b0;
      done_q  <= 1'b0;
      abort_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      cnt_q  <= (timed && !tick && !abort_hit) ? cnt_q + DIV_W'(1) : '0;
      if (abort_hit) begin
        abort_q <= 1'b1;
        sclk_q  <= 1'b0;
      end else begin
        unique case (state)
          IDLE: if (cfg_start) begin
            abort_q <= 1'b0;
            if (cfg_len == '0) done_q <= 1'b1;
            else begin
              addr_q  <= {cfg_addr[ADDR_W-1:2], 2'b00};
              left_q  <= cfg_len;
              div_q   <= (cfg_div == '0) ? DIV_W'(1) : cfg_div;
              first_q <= 1'b1;
              bit_q   <= '0;
            end
          end
          FETCH: if (rd_ack) begin
            tx_sh   <= rd_data;
            left_q  <= left_q - LEN_W'(1);
            first_q <= 1'b0;
            bit_q   <= '0;
          end
          SHIFT: if (tick) begin
            sclk_q <= !sclk_q;
            if (!sclk_q) rx_sh <= {rx_sh[30:0], spi_miso};
            else begin
              tx_sh <= {tx_sh[30:0], 1'b0};
              bit_q <= bit_q + 5'd1;
              if (bit_q == 5'd31) rx_q <= rx_sh;
            end
          end
          NEXT:    if (left_q != '0) addr_q <= addr_q + ADDR_W'(4);
          CS_HOLD: if (tick) done_q <= 1'b1;
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_dma_seq.sv
// Directed bench for spi_dma_seq: MISO looped back to MOSI, a req/ack memory
// responder with programmable latency, and a negedge monitor that counts SCLK
// edges, done pulses, CS integrity and cycle latencies.
module tb_spi_dma_seq;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        cfg_start = 1'b0, cfg_abort = 1'b0;
  logic [31:0] cfg_addr = '0;
  logic [15:0] cfg_len = '0;
  logic [7:0]  cfg_div = '0;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        rd_ack = 1'b0;
  logic [31:0] rd_data = '0;
  logic        spi_sclk, spi_mosi, spi_miso, spi_cs_n;
  logic        busy, done, aborted;
  logic [31:0] rx_word;
  logic [15:0] words_left;

  always #5 ACLK = ~ACLK;
  assign spi_miso = spi_mosi;

  spi_dma_seq #(.ADDR_W(32), .LEN_W(16), .DIV_W(8)) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .cfg_start(cfg_start), .cfg_abort(cfg_abort), .cfg_addr(cfg_addr),
    .cfg_len(cfg_len), .cfg_div(cfg_div),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
    .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso), .spi_cs_n(spi_cs_n),
    .busy(busy), .done(done), .aborted(aborted), .rx_word(rx_word), .words_left(words_left)
  );

  int checks = 0, errors = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // memory responder
  logic        mon_clr = 1'b0;
  int          ack_lat = 1, lat_cnt = 0, n_req = 0;
  logic [31:0] dpat = '0;
  logic [31:0] addr_log [8];
  logic [15:0] wl_log [8];

  always @(negedge ACLK) begin
    if (mon_clr) n_req = 0;
    if (rd_ack) begin
      rd_ack  = 1'b0;
      lat_cnt = 0;
      if (n_req > 0 && n_req <= 8) wl_log[n_req-1] = words_left;
    end else if (rd_req) begin
      if (lat_cnt >= ack_lat) begin
        rd_ack  = 1'b1;
        rd_data = dpat ^ (32'h11111111 * n_req);
        if (n_req < 8) addr_log[n_req] = rd_addr;
        n_req++;
      end else lat_cnt++;
    end else lat_cnt = 0;
  end

  // monitor
  int          cyc = 0, rises, dones, start_cyc, done_cyc, min_per, max_per, last_rise, per;
  int          cs_glitch, sclk_gap;
  bit          start_seen, done_seen, req_seen, cs_seen, busy_seen, cs_on;
  logic        sclk_prev = 1'b0;
  logic [31:0] mosi_log, sig;

  always @(negedge ACLK) begin
    cyc++;
    if (mon_clr) begin
      rises = 0; dones = 0; start_seen = 0; done_seen = 0; start_cyc = 0; done_cyc = 0;
      min_per = 1000; max_per = 0; last_rise = -1; cs_glitch = 0; sclk_gap = 0;
      req_seen = 0; cs_seen = 0; busy_seen = 0; cs_on = 0; mosi_log = '0; sig = '0;
    end else begin
      sig = (sig * 33) ^ {26'd0, spi_sclk, spi_mosi, spi_cs_n, rd_req, done, busy};
      if (cfg_start && !start_seen) begin start_seen = 1; start_cyc = cyc; end
      if (done) begin
        dones++;
        if (!done_seen) begin done_seen = 1; done_cyc = cyc; end
      end
      if (spi_sclk && !sclk_prev) begin
        rises++;
        mosi_log = {mosi_log[30:0], spi_mosi};
        if (last_rise >= 0) begin
          per = cyc - last_rise;
          if (per < min_per) min_per = per;
          if (per > max_per) max_per = per;
        end
        last_rise = cyc;
      end
      if (rd_req) req_seen = 1;
      if (busy) busy_seen = 1;
      if (!spi_cs_n) begin cs_seen = 1; cs_on = 1; end
      else if (cs_on && busy) cs_glitch++;
      if (rd_req && spi_sclk) sclk_gap++;
    end
    sclk_prev = spi_sclk;
  end

  task automatic start_xfer(input logic [31:0] a, input logic [15:0] l, input logic [7:0] d,
                            input int lat, input logic [31:0] pat);
    @(posedge ACLK); #1;
    mon_clr = 1'b1; ack_lat = lat; dpat = pat;
    @(posedge ACLK); #1;
    mon_clr = 1'b0;
    cfg_addr = a; cfg_len = l; cfg_div = d; cfg_start = 1'b1;
    @(posedge ACLK); #1;
    cfg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int k = 0;
    while (dones == 0 && k < budget) begin @(posedge ACLK); k++; end
    repeat (3) @(posedge ACLK);
    #1;
    chk("done_once", 64'(dones), 64'd1);
  endtask

  task automatic wait_rises(input int n, input int budget);
    int k = 0;
    while (rises < n && k < budget) begin @(posedge ACLK); k++; end
    chk("rise_wait", 64'(rises >= n), 64'd1);
  endtask

  task automatic chk_rst(input string tag);
    chk({tag, "_ctl"}, 64'({rd_req, spi_sclk, spi_mosi, spi_cs_n, busy, done, aborted}), 64'b0001000);
    chk({tag, "_addr"}, 64'(rd_addr), 64'd0);
    chk({tag, "_rx"}, 64'(rx_word), 64'd0);
    chk({tag, "_left"}, 64'(words_left), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] s1;
  int          l1;

  initial begin
    repeat (3) @(posedge ACLK);
    #1 chk_rst("init");
    #2 ARESET = 1'b0;

    // single word, div 2, loopback
    start_xfer(32'h1000, 16'd1, 8'd2, 1, 32'hA5A50F0F);
    wait_done(400);
    chk("t1_rises", 64'(rises), 64'd32);
    chk("t1_mosi", 64'(mosi_log), 64'hA5A50F0F);
    chk("t1_rx", 64'(rx_word), 64'hA5A50F0F);
    chk("t1_per_min", 64'(min_per), 64'd4);
    chk("t1_per_max", 64'(max_per), 64'd4);
    chk("t1_lat", 64'(done_cyc - start_cyc), 64'd136);
    chk("t1_idle", 64'({spi_cs_n, busy}), 64'b10);

    // three words, slow memory
    start_xfer(32'h2000, 16'd3, 8'd1, 5, 32'h12345678);
    wait_done(600);
    chk("t2_nreq", 64'(n_req), 64'd3);
    chk("t2_a0", 64'(addr_log[0]), 64'h2000);
    chk("t2_a1", 64'(addr_log[1]), 64'h2004);
    chk("t2_a2", 64'(addr_log[2]), 64'h2008);
    chk("t2_wl0", 64'(wl_log[0]), 64'd2);
    chk("t2_wl1", 64'(wl_log[1]), 64'd1);
    chk("t2_wl2", 64'(wl_log[2]), 64'd0);
    chk("t2_rises", 64'(rises), 64'd96);
    chk("t2_cs_glitch", 64'(cs_glitch), 64'd0);
    chk("t2_sclk_gap", 64'(sclk_gap), 64'd0);
    chk("t2_rx", 64'(rx_word), 64'h3016745A);
    chk("t2_lat", 64'(done_cyc - start_cyc), 64'd216);

    // zero-length command
    start_xfer(32'h5000, 16'd0, 8'd3, 1, 32'h0);
    repeat (5) @(posedge ACLK);
    #1;
    chk("t3_dones", 64'(dones), 64'd1);
    chk("t3_lat", 64'(done_cyc - start_cyc), 64'd1);
    chk("t3_quiet", 64'({req_seen, cs_seen, busy_seen}), 64'b000);

    // abort in the middle of word 2
    start_xfer(32'h6000, 16'd4, 8'd1, 1, 32'h0F0F0F0F);
    wait_rises(40, 300);
    @(posedge ACLK); #1 cfg_abort = 1'b1;
    @(posedge ACLK); #1 cfg_abort = 1'b0;
    chk("t4_abort", 64'({rd_req, spi_cs_n, busy, aborted, spi_sclk, spi_mosi}), 64'b010100);
    repeat (20) @(posedge ACLK);
    #1 chk("t4_no_done", 64'(dones), 64'd0);
    start_xfer(32'h7000, 16'd1, 8'd1, 1, 32'hC3C3C3C3);
    chk("t4_clr", 64'(aborted), 64'd0);
    wait_done(300);
    chk("t4_rx", 64'(rx_word), 64'hC3C3C3C3);
    chk("t4_lat", 64'(done_cyc - start_cyc), 64'd70);

    // div 0 behaves as div 1
    start_xfer(32'h3000, 16'd1, 8'd1, 1, 32'h5A5A1234);
    wait_done(300);
    s1 = sig; l1 = done_cyc - start_cyc;
    chk("t5_lat1", 64'(l1), 64'd70);
    start_xfer(32'h3000, 16'd1, 8'd0, 1, 32'h5A5A1234);
    wait_done(300);
    chk("t5_lat0", 64'(done_cyc - start_cyc), 64'd70);
    chk("t5_sig", 64'(sig), 64'(s1));

    // start while busy is ignored
    start_xfer(32'h4000, 16'd2, 8'd1, 1, 32'h600DF00D);
    wait_rises(5, 200);
    @(posedge ACLK); #1;
    cfg_start = 1'b1; cfg_addr = 32'h8000; cfg_len = 16'd5; cfg_div = 8'd7;
    @(posedge ACLK); #1 cfg_start = 1'b0;
    wait_done(600);
    chk("t5_busy_nreq", 64'(n_req), 64'd2);
    chk("t5_busy_a1", 64'(addr_log[1]), 64'h4004);
    chk("t5_busy_rises", 64'(rises), 64'd64);
    chk("t5_busy_lat", 64'(done_cyc - start_cyc), 64'd137);
    chk("t5_busy_rx", 64'(rx_word), 64'h711CE11C);

    // address wrap
    start_xfer(32'hFFFFFFFC, 16'd2, 8'd1, 1, 32'h0);
    wait_done(600);
    chk("t5_wrap_a0", 64'(addr_log[0]), 64'hFFFFFFFC);
    chk("t5_wrap_a1", 64'(addr_log[1]), 64'h0);

    // reset mid-shift, then recover
    start_xfer(32'h9000, 16'd1, 8'd1, 1, 32'hDEADBEEF);
    wait_rises(10, 200);
    @(posedge ACLK); #3 ARESET = 1'b1;
    #1 chk_rst("t6");
    @(posedge ACLK); #3 ARESET = 1'b0;
    start_xfer(32'hA000, 16'd1, 8'd1, 1, 32'h13572468);
    wait_done(300);
    chk("t6_rx", 64'(rx_word), 64'h13572468);
    chk("t6_lat", 64'(done_cyc - start_cyc), 64'd70);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
